// File: rtl/btn_debounce.sv
// btn_debounce: push-button conditioning for the button CSR and interrupt controller.
// Each lane synchronises its raw pin, filters bounce with a run-length counter, and
// emits a stable level plus registered one-cycle press/release pulses. Enabled edges
// are latched into sticky pending bits whose OR drives a level interrupt.
//
// Lane FSM
//   state      | meaning
//   -----------+-----------------------------------------------------------------
//   ST_STABLE  | synchronised pin equals debounced level; counter held at zero
//   ST_COUNT   | pin differs from level; counter tracks consecutive mismatch cycles
//
// The level flips on the DebounceCycles-th consecutive mismatch cycle. Any cycle in
// which the pin agrees with the level again drops the lane back to ST_STABLE with
// no pulse, so a glitch shorter than DebounceCycles never reaches the output.
module btn_debounce #(
    parameter int BtnWidth       = 4,
    parameter int SyncStages     = 2,
    parameter int DebounceCycles = 1_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [BtnWidth-1:0] btn_in,
    input  logic [BtnWidth-1:0] rise_en,
    input  logic [BtnWidth-1:0] fall_en,
    input  logic [BtnWidth-1:0] pending_clr,
    output logic [BtnWidth-1:0] btn_out,
    output logic [BtnWidth-1:0] btn_rise,
    output logic [BtnWidth-1:0] btn_fall,
    output logic [BtnWidth-1:0] pending,
    output logic                irq
);

    // Counter only has to reach DebounceCycles-1, where the lane toggles and clears it.
    localparam int              CntW    = $clog2(DebounceCycles);
    localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_COUNT  = 1'b1
    } lane_state_t;

    genvar i;
    generate
        for (i = 0; i < BtnWidth; i++) begin : g_lane
            logic [SyncStages-1:0] sync_q;
            logic                  sync_lvl;
            lane_state_t           state;
            logic [CntW-1:0]       cnt;
            logic                  lvl_q;
            logic                  rise_q;
            logic                  fall_q;
            logic                  pend_q;

            // Metastability filter: shift the raw pin through SyncStages flops.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= {sync_q[SyncStages-2:0], btn_in[i]};
                end
            end

            assign sync_lvl = sync_q[SyncStages-1];

            // Debounce FSM: count consecutive mismatches, toggle level and pulse on the last one.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    state  <= ST_STABLE;
                    cnt    <= '0;
                    lvl_q  <= 1'b0;
                    rise_q <= 1'b0;
                    fall_q <= 1'b0;
                end else begin
                    rise_q <= 1'b0;
                    fall_q <= 1'b0;
                    case (state)
                        ST_STABLE: begin
                            if (sync_lvl != lvl_q) begin
                                state <= ST_COUNT;
                                cnt   <= CntOne;
                            end else begin
                                cnt   <= '0;
                            end
                        end
                        ST_COUNT: begin
                            if (sync_lvl == lvl_q) begin
                                state <= ST_STABLE;
                                cnt   <= '0;
                            end else if (cnt == CntLast) begin
                                lvl_q  <= ~lvl_q;
                                rise_q <= ~lvl_q;
                                fall_q <= lvl_q;
                                state  <= ST_STABLE;
                                cnt    <= '0;
                            end else begin
                                cnt <= cnt + CntOne;
                            end
                        end
                        default: begin
                            state <= ST_STABLE;
                            cnt   <= '0;
                        end
                    endcase
                end
            end

            // Sticky pending bit: enabled edge sets it, clear strobe drops it, set wins.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    pend_q <= 1'b0;
                end else begin
                    pend_q <= (pend_q & ~pending_clr[i])
                            | (rise_q & rise_en[i])
                            | (fall_q & fall_en[i]);
                end
            end

            assign btn_out[i]  = lvl_q;
            assign btn_rise[i] = rise_q;
            assign btn_fall[i] = fall_q;
            assign pending[i]  = pend_q;
        end
    endgenerate

    assign irq = |pending;

endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed scenarios with literal expectations, then random bouncing
// stimulus, all cross-checked every cycle against a run-length model of the debouncer.
module tb_btn_debounce;

    localparam int W = 4;
    localparam int S = 2;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] btn_in = '0;
    logic [W-1:0] rise_en = '0;
    logic [W-1:0] fall_en = '0;
    logic [W-1:0] pending_clr = '0;
    logic [W-1:0] btn_out, btn_rise, btn_fall, pending;
    logic         irq;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    btn_debounce #(.BtnWidth(W), .SyncStages(S), .DebounceCycles(D)) dut (
        .clk(clk), .reset(reset), .btn_in(btn_in), .rise_en(rise_en),
        .fall_en(fall_en), .pending_clr(pending_clr), .btn_out(btn_out),
        .btn_rise(btn_rise), .btn_fall(btn_fall), .pending(pending), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model: pin delayed by S samples; level flips after D consecutive
    // cycles in which the delayed pin disagrees with it.
    logic [W-1:0] hist [S];
    int           run [W];
    logic [W-1:0] m_lvl = '0, m_rise = '0, m_fall = '0, m_pend = '0;
    logic [W-1:0] m_seen;

    initial begin
        for (int k = 0; k < S; k++) hist[k] = '0;
        for (int l = 0; l < W; l++) run[l] = 0;
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < S; k++) hist[k] = '0;
            for (int l = 0; l < W; l++) run[l] = 0;
            m_lvl = '0; m_rise = '0; m_fall = '0; m_pend = '0;
        end else begin
            m_seen = hist[S-1];
            m_pend = (m_pend & ~pending_clr) | (m_rise & rise_en) | (m_fall & fall_en);
            m_rise = '0;
            m_fall = '0;
            for (int l = 0; l < W; l++) begin
                if (m_seen[l] != m_lvl[l]) begin
                    run[l] = run[l] + 1;
                    if (run[l] == D) begin
                        m_lvl[l] = ~m_lvl[l];
                        if (m_lvl[l]) m_rise[l] = 1'b1;
                        else          m_fall[l] = 1'b1;
                        run[l] = 0;
                    end
                end else begin
                    run[l] = 0;
                end
            end
            for (int k = S - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = btn_in;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of the DUT against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_btn_out",  32'(btn_out),  32'(m_lvl));
            chk("model_btn_rise", 32'(btn_rise), 32'(m_rise));
            chk("model_btn_fall", 32'(btn_fall), 32'(m_fall));
            chk("model_pending",  32'(pending),  32'(m_pend));
            chk("model_irq",      32'(irq),      32'(|m_pend));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int hold [W];

    initial begin
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b1;

        // Idle after reset: nothing moves.
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("idle_pulses", 32'(btn_rise | btn_fall), 0);
        end
        chk("idle_out", 32'(btn_out), 0);
        chk("idle_pending", 32'(pending), 0);
        chk("idle_irq", 32'(irq), 0);

        // Clean press on lane 0.
        rise_en = 4'b0001;
        btn_in[0] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("press0_out",  32'(btn_out[0]),  32'(k >= 10));
            chk("press0_rise", 32'(btn_rise[0]), 32'(k == 10));
            chk("press0_pend", 32'(pending[0]),  32'(k >= 11));
            chk("press0_irq",  32'(irq),         32'(k >= 11));
        end

        // Bouncing press on lane 1.
        btn_in[1] = 1'b1; repeat (5) begin tick(); chk("bounce1_out", 32'(btn_out[1]), 0); end
        btn_in[1] = 1'b0; repeat (3) begin tick(); chk("bounce1_out", 32'(btn_out[1]), 0); end
        btn_in[1] = 1'b1; repeat (6) begin tick(); chk("bounce1_out", 32'(btn_out[1]), 0); end
        btn_in[1] = 1'b0; repeat (2) begin tick(); chk("bounce1_out", 32'(btn_out[1]), 0); end
        btn_in[1] = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            chk("bounce1_settle_out", 32'(btn_out[1]),  32'(k >= 10));
            chk("bounce1_rise",       32'(btn_rise[1]), 32'(k == 10));
        end

        // Release on lane 0 with a simultaneous clear: set wins.
        fall_en = 4'b0001;
        btn_in[0] = 1'b0;
        repeat (9) tick();
        chk("rel0_prefall", 32'(btn_fall[0]), 0);
        tick();
        chk("rel0_fall", 32'(btn_fall[0]), 1);
        chk("rel0_pend_before", 32'(pending[0]), 1);
        pending_clr[0] = 1'b1;
        tick();
        pending_clr[0] = 1'b0;
        chk("set_wins_pend", 32'(pending[0]), 1);
        repeat (3) tick();
        pending_clr[0] = 1'b1;
        tick();
        pending_clr[0] = 1'b0;
        chk("lone_clr_pend", 32'(pending[0]), 0);
        chk("lone_clr_irq", 32'(irq), 0);

        // Reset in the middle of a lane 2 count, pin still held.
        btn_in[2] = 1'b1;
        repeat (8) tick();
        reset = 1'b0;
        #1;
        chk("rst_async_out", 32'(btn_out), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_out", 32'(btn_out), 0);
            chk("rst_pulse", 32'(btn_rise | btn_fall), 0);
            chk("rst_pend", 32'(pending), 0);
            chk("rst_irq", 32'(irq), 0);
        end
        reset = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            chk("post_rst_rise2", 32'(btn_rise[2]), 32'(k == 10));
            chk("post_rst_rise", 32'(btn_rise), (k == 10) ? 32'h6 : 32'h0);
        end
        btn_in = '0;
        repeat (15) tick();

        // Lanes 0 and 3 step together.
        rise_en = 4'b1001;
        btn_in = 4'b1001;
        for (int k = 1; k <= 11; k++) begin
            tick();
            chk("dual_rise", 32'(btn_rise), (k == 10) ? 32'h9 : 32'h0);
        end
        chk("dual_pend", 32'(pending), 32'h9);
        chk("dual_irq", 32'(irq), 1);

        // Random bouncing pins, enables and clears.
        for (int l = 0; l < W; l++) hold[l] = $urandom_range(14, 1);
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int l = 0; l < W; l++) begin
                if (hold[l] == 0) begin
                    btn_in[l] = ~btn_in[l];
                    hold[l] = ($urandom_range(3, 0) == 0) ? $urandom_range(30, 10)
                                                          : $urandom_range(9, 1);
                end else begin
                    hold[l] = hold[l] - 1;
                end
            end
            if ($urandom_range(31, 0) == 0) rise_en = W'($urandom);
            if ($urandom_range(31, 0) == 0) fall_en = W'($urandom);
            pending_clr = '0;
            for (int l = 0; l < W; l++)
                if ($urandom_range(5, 0) == 0) pending_clr[l] = 1'b1;
            if (c == 1500) reset = 1'b0;
            if (c == 1503) reset = 1'b1;
        end
        pending_clr = '0;
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
